// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory port toward IM1 plus the decode-side
// hand-off. The fetch unit is the master side.
interface if_fetch_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IM_DEPTH   = 16384
);
    localparam int AW = $clog2(IM_DEPTH);

    logic                  IM_OE;
    logic [AW-1:0]         IM_A;
    logic [DATA_WIDTH-1:0] IM_DO;
    logic                  stall;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  if_valid;
    logic [DATA_WIDTH-1:0] if_pc;
    logic [DATA_WIDTH-1:0] if_inst;
    logic                  misalign;
    logic [31:0]           fetch_cnt;

    modport master (
        output IM_OE, IM_A, if_valid, if_pc, if_inst, misalign, fetch_cnt,
        input  IM_DO, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  IM_OE, IM_A, if_valid, if_pc, if_inst, misalign, fetch_cnt,
        output IM_DO, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, drives the one-cycle-latency
// IM port and presents {pc, inst, valid} to decode; stall re-issues the held address.
module if_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    IM_DEPTH   = 16384,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic             clk,
    input  logic             rst,
    if_fetch_unit_if.master  bus
);
    localparam int AW = $clog2(IM_DEPTH);

    typedef enum logic [1:0] {S_RST, S_PRIME, S_RUN} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] issued_pc, next_pc, redirect_aligned;
    logic                  misalign_q;
    logic [31:0]           cnt_q;

    assign redirect_aligned = {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};

    always_comb begin
        state_nxt    = state;
        next_pc      = RESET_PC;
        bus.IM_OE    = 1'b0;
        bus.if_valid = 1'b0;
        bus.if_pc    = issued_pc;
        bus.if_inst  = '0;
        case (state)
            S_RST: begin
                state_nxt = S_PRIME;
                bus.if_pc = RESET_PC;
            end
            S_PRIME: begin
                state_nxt = S_RUN;
                bus.IM_OE = 1'b1;
                if (bus.redirect_valid) next_pc = redirect_aligned;
            end
            S_RUN: begin
                bus.IM_OE    = 1'b1;
                bus.if_valid = 1'b1;
                bus.if_inst  = bus.IM_DO;
                // redirect beats stall; stall re-reads the same word so IM_DO holds
                if (bus.redirect_valid) next_pc = redirect_aligned;
                else if (bus.stall)     next_pc = issued_pc;
                else                    next_pc = issued_pc + DATA_WIDTH'(4);
            end
            default: state_nxt = S_RST;
        endcase
    end

    assign bus.IM_A      = next_pc[AW+1:2];
    assign bus.misalign  = misalign_q;
    assign bus.fetch_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_RST;
            issued_pc  <= RESET_PC;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state      <= state_nxt;
            if (state != S_RST) issued_pc <= next_pc;
            misalign_q <= (state != S_RST) && bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
            if (state == S_RUN && !bus.stall && !bus.redirect_valid)
                cnt_q <= cnt_q + 32'd1;
        end
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end inside CPU; drives the instruction-memory port of the one-cycle-delay SRAM_wrapper instance (IM1).
- Owns the fetch PC, issues word addresses, aligns the one-cycle SRAM read latency, and hands {pc, instruction, valid} to decode.
- Handles decode stall and branch/jump redirect without a skid buffer: on stall it re-issues the held address.

Parameters:
- DATA_WIDTH, 32, instruction/PC width (`DATA_WIDTH).
- IM_DEPTH, 16384, instruction-memory depth in words (`IM_DEPTH); AW = $clog2(IM_DEPTH).
- RESET_PC, 32'h0000_0000, first fetch byte address after reset.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- IM_OE  out  1  IM output enable.
- IM_A  out  AW  IM word address; combinational, sampled by SRAM at the clock edge.
- IM_DO  in  DATA_WIDTH  IM read data; valid the cycle after the address is issued.
- stall  in  1  decode cannot accept the current instruction; hold.
- redirect_valid  in  1  taken branch/jump; highest priority after reset.
- redirect_pc  in  DATA_WIDTH  redirect target byte address.
- if_valid  out  1  if_pc/if_inst hold a fetched instruction this cycle.
- if_pc  out  DATA_WIDTH  byte address of if_inst.
- if_inst  out  DATA_WIDTH  instruction; equals IM_DO when if_valid=1, else 0.
- misalign  out  1  one-cycle pulse: accepted redirect_pc[1:0] != 0.
- fetch_cnt  out  32  count of instructions delivered (if_valid & ~stall cycles).

Behaviour:
- State machine: S_RST -> S_PRIME -> S_RUN; S_RUN is self-looping.
- S_RST: entered at any edge with rst=0. Outputs: IM_OE=0, IM_A=RESET_PC[AW+1:2], if_valid=0, if_pc=RESET_PC, if_inst=0, misalign=0, fetch_cnt=0. Advances to S_PRIME at the first edge with rst=1.
- S_PRIME: IM_OE=1, IM_A=RESET_PC word, if_valid=0. Registers issued_pc=RESET_PC and advances to S_RUN. A redirect in S_PRIME issues redirect_pc instead.
- S_RUN: IM_OE=1, if_valid=1, if_pc=issued_pc (the address issued the previous cycle), if_inst=IM_DO.
- S_RUN next-address priority:
  - redirect_valid: issue {redirect_pc[31:2],2'b00}.
  - else stall: re-issue issued_pc so IM_DO repeats.
  - else: issue issued_pc+4.
  - issued_pc takes the issued value at the edge.
- Redirect latency: the target instruction is presented with if_valid=1 in the cycle after redirect_valid (1-cycle penalty). Flushing the wrong-path instruction present during the redirect cycle is decode's job.
- Redirect with stall in the same cycle: redirect wins and stall is ignored. This cycle's instruction is not counted.
- misalign: registered, asserted the cycle after an accepted redirect whose redirect_pc[1:0] != 0. Fetch proceeds from the aligned address.
- PC arithmetic: modulo 2^32. IM_A = issued_pc[AW+1:2], so fetch wraps modulo IM size (0xFFFC -> 0x0000 for 64 KB).
- fetch_cnt: +1 on each edge where state=S_RUN, if_valid=1, stall=0, redirect_valid=0. Wraps modulo 2^32.
- Reset mid-operation: rst=0 overrides stall and redirect. The next cycle is S_RST with all outputs at reset values, and in-flight data is discarded. Fetch restarts from RESET_PC.
- IM_OE is never 0 outside S_RST. No X may propagate to if_inst when if_valid=0.

Test Plan:
- Reset release, IM preloaded with word[i]=0x1000_0000+i, no stall:
  - cycle after release: if_valid=0;
  - following cycles: if_pc=0,4,8,… with if_inst=0x1000_0000,…0001,…0002;
  - fetch_cnt=3 after three delivered cycles.
- stall held 3 cycles while if_pc=0x8:
  - if_pc=0x8 and if_inst=word[2] stable for 4 cycles, IM_A=2 throughout;
  - then if_pc=0xC; fetch_cnt not incremented during stall.
- redirect_valid with redirect_pc=0x40 while if_pc=0x10:
  - next cycle if_pc=0x40, if_inst=word[16];
  - then 0x44; misalign stays 0.
- redirect_valid and stall in the same cycle, redirect_pc=0x22:
  - next cycle if_pc=0x20, misalign=1 for one cycle;
  - stall ignored; fetch_cnt unchanged for that cycle.
- Run to issued_pc=0xFFFC (IM_DEPTH=16384): IM_A=0x3FFF, next IM_A=0x0000, and if_pc=0x1_0000 with if_inst=word[0].
- rst=0 asserted for one cycle during a redirect: next cycle IM_OE=0, if_valid=0, fetch_cnt=0; after release, fetch restarts at RESET_PC, not the redirect target.
